// File: rtl/vga_scaled_renderer.sv
// Upscaled frame-buffer window renderer with latency-matched sync/DE pipeline.
// Optional macro TEST_PATTERN_EN adds an 8-bar test pattern and its enable input.
module vga_scaled_renderer #(
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter int          CW          = 10,
    parameter int          FB_W        = 320,
    parameter int          FB_H        = 240,
    parameter int          SCALE_SHIFT = 1,
    parameter int          WIN_X0      = 0,
    parameter int          WIN_Y0      = 0,
    parameter int          AW          = 17,
    parameter int          FB_LATENCY  = 2,
    parameter int          OUT_W       = 8,
    parameter logic [23:0] BORDER_RGB  = 24'h000040
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW-1:0]    x_in,
    input  logic [CW-1:0]    y_in,
    input  logic             active_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [1:0]       display_mode,
    input  logic [7:0]       threshold,
`ifdef TEST_PATTERN_EN
    input  logic             test_pattern_enable,
`endif
    output logic [AW-1:0]    fb_addr,
    output logic             fb_rd_en,
    input  logic [15:0]      fb_data,
    output logic [OUT_W-1:0] vga_r,
    output logic [OUT_W-1:0] vga_g,
    output logic [OUT_W-1:0] vga_b,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out
);

    localparam int L      = FB_LATENCY + 2;
    localparam int PD     = L - 1;
    localparam int WIN_X1 = WIN_X0 + (FB_W << SCALE_SHIFT);
    localparam int WIN_Y1 = WIN_Y0 + (FB_H << SCALE_SHIFT);
    localparam logic [CW-1:0] ROW_MASK = CW'((1 << SCALE_SHIFT) - 1);
    localparam logic [7:0] BORDER_R = BORDER_RGB[23:16];
    localparam logic [7:0] BORDER_G = BORDER_RGB[15:8];
    localparam logic [7:0] BORDER_B = BORDER_RGB[7:0];

    logic [CW-1:0] x_off, y_off, col;
    logic          in_act, in_x, in_y, in_win, line_start, frame_start, row_step, rd_now;
    logic [AW-1:0] row_base, row_base_cur;
    logic [1:0]    mode_sh;
    logic [7:0]    thr_sh;

    logic [PD-1:0] act_p, win_p, hs_p, vs_p;

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic          tp_sh, tp_now;
    logic [CW-1:0] bar_cnt, bar_cnt_cur;
    logic [2:0]    bar_idx, bar_idx_cur;
    logic [PD-1:0] tp_p;
    logic [2:0]    idx_p [PD];
`endif

    // Stage A decode. row_base_cur already holds this line's base on its x==0
    // cycle, so the first pixel of every line addresses the correct row.
    always_comb begin
        x_off       = x_in - CW'(WIN_X0);
        y_off       = y_in - CW'(WIN_Y0);
        col         = x_off >> SCALE_SHIFT;
        in_act      = active_in && (int'(x_in) < H_ACTIVE) && (int'(y_in) < V_ACTIVE);
        in_x        = (int'(x_in) >= WIN_X0) && (int'(x_in) < WIN_X1);
        in_y        = (int'(y_in) >= WIN_Y0) && (int'(y_in) < WIN_Y1);
        in_win      = in_act && in_x && in_y;
        line_start  = in_act && (x_in == '0);
        frame_start = line_start && (y_in == '0);
        row_step    = (int'(y_in) > WIN_Y0) && in_y && ((y_off & ROW_MASK) == '0);
        row_base_cur = row_base;
        if (line_start) begin
            if (y_in == CW'(WIN_Y0))
                row_base_cur = '0;
            else if (row_step)
                row_base_cur = row_base + AW'(FB_W);
        end
`ifdef TEST_PATTERN_EN
        tp_now      = frame_start ? test_pattern_enable : tp_sh;
        bar_cnt_cur = line_start ? '0 : bar_cnt;
        bar_idx_cur = line_start ? 3'd0 : bar_idx;
        rd_now      = in_win && !tp_now;
`else
        rd_now      = in_win;
`endif
    end

    // fb_rd_en marks a request whose data must be on fb_data exactly
    // FB_LATENCY cycles later; there is no backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
            row_base <= '0;
        end else begin
            row_base <= row_base_cur;
            fb_rd_en <= rd_now;
            if (rd_now)
                fb_addr <= row_base_cur + AW'(col);
        end
    end

    // Frame-start shadows keep mode changes from tearing a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_sh <= 2'b00;
            thr_sh  <= 8'h80;
        end else if (frame_start) begin
            mode_sh <= display_mode;
            thr_sh  <= threshold;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_p <= '0;
            win_p <= '0;
            hs_p  <= '1;
            vs_p  <= '1;
        end else begin
            act_p <= {act_p[PD-2:0], in_act};
            win_p <= {win_p[PD-2:0], in_win};
            hs_p  <= {hs_p[PD-2:0], hsync_in};
            vs_p  <= {vs_p[PD-2:0], vsync_in};
        end
    end

`ifdef TEST_PATTERN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_sh   <= 1'b0;
            bar_cnt <= '0;
            bar_idx <= 3'd0;
            tp_p    <= '0;
            for (int i = 0; i < PD; i++) idx_p[i] <= 3'd0;
        end else begin
            if (frame_start) tp_sh <= test_pattern_enable;
            if (in_act) begin
                if (bar_cnt_cur == CW'(BAR_W - 1)) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx_cur + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt_cur + CW'(1);
                    bar_idx <= bar_idx_cur;
                end
            end
            tp_p     <= {tp_p[PD-2:0], tp_now};
            idx_p[0] <= bar_idx_cur;
            for (int i = 1; i < PD; i++) idx_p[i] <= idx_p[i-1];
        end
    end
`endif

    logic [7:0] r8, g8, b8, luma, cr, cg, cb;

    always_comb begin
        r8   = {fb_data[15:11], fb_data[15:13]};
        g8   = {fb_data[10:5],  fb_data[10:9]};
        b8   = {fb_data[4:0],   fb_data[4:2]};
        luma = (r8 >> 2) + (g8 >> 1) + (b8 >> 3);
        cr   = r8;
        cg   = g8;
        cb   = b8;
        case (mode_sh)
            2'b01: begin
                cr = luma;
                cg = luma;
                cb = luma;
            end
            2'b10: begin
                cr = (luma > thr_sh) ? 8'hFF : 8'h00;
                cg = cr;
                cb = cr;
            end
            2'b11: begin
                cr = b8;
                cg = r8;
                cb = g8;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            de_out    <= act_p[PD-1];
            hsync_out <= hs_p[PD-1];
            vsync_out <= vs_p[PD-1];
            if (!act_p[PD-1]) begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
`ifdef TEST_PATTERN_EN
            else if (tp_p[PD-1]) begin
                vga_r <= {OUT_W{~idx_p[PD-1][2]}};
                vga_g <= {OUT_W{~idx_p[PD-1][1]}};
                vga_b <= {OUT_W{~idx_p[PD-1][0]}};
            end
`endif
            else if (!win_p[PD-1]) begin
                vga_r <= BORDER_R[7 -: OUT_W];
                vga_g <= BORDER_G[7 -: OUT_W];
                vga_b <= BORDER_B[7 -: OUT_W];
            end else begin
                vga_r <= cr[7 -: OUT_W];
                vga_g <= cg[7 -: OUT_W];
                vga_b <= cb[7 -: OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_vga_scaled_renderer.sv
// Bench for vga_scaled_renderer: a default full-raster instance and an offset
// window instance (deeper memory latency, 5-bit output) share one sparse raster.
module tb_vga_scaled_renderer;

    localparam int FBL_A = 2;
    localparam int FBL_B = 3;
    localparam int LA    = FBL_A + 2;
    localparam int LB    = FBL_B + 2;
    localparam logic [26:0] RST_PIX = {1'b0, 1'b1, 1'b1, 24'h0};

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  x_in = '0, y_in = '0;
    logic        active_in = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [1:0]  display_mode = 2'b00;
    logic [7:0]  threshold = 8'h80;

    logic [16:0] fb_addr_a, fb_addr_b;
    logic        fb_rd_en_a, fb_rd_en_b;
    logic [15:0] fb_data_a, fb_data_b;
    logic [7:0]  vga_r_a, vga_g_a, vga_b_a;
    logic [4:0]  vga_r_b, vga_g_b, vga_b_b;
    logic        hs_a, vs_a, de_a, hs_b, vs_b, de_b;

    vga_scaled_renderer u_dut_a (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .active_in(active_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .display_mode(display_mode),
        .threshold(threshold),
`ifdef TEST_PATTERN_EN
        .test_pattern_enable(1'b0),
`endif
        .fb_addr(fb_addr_a), .fb_rd_en(fb_rd_en_a), .fb_data(fb_data_a),
        .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
        .hsync_out(hs_a), .vsync_out(vs_a), .de_out(de_a)
    );

    vga_scaled_renderer #(
        .FB_W(160), .FB_H(100), .SCALE_SHIFT(0), .WIN_X0(100), .WIN_Y0(40),
        .FB_LATENCY(FBL_B), .OUT_W(5)
    ) u_dut_b (
        .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .active_in(active_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .display_mode(display_mode),
        .threshold(threshold),
`ifdef TEST_PATTERN_EN
        .test_pattern_enable(1'b0),
`endif
        .fb_addr(fb_addr_b), .fb_rd_en(fb_rd_en_b), .fb_data(fb_data_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .hsync_out(hs_b), .vsync_out(vs_b), .de_out(de_b)
    );

    // frame-buffer contents: either a constant or an address hash
    bit          const_en = 1'b0;
    logic [15:0] const_val = 16'h0000;

    function automatic logic [15:0] mem_word(int a);
        if (const_en) return const_val;
        return 16'((a * 40503) ^ (a >> 5) ^ 23100);
    endfunction

    logic [15:0] mp_a [FBL_A];
    logic [15:0] mp_b [FBL_B];
    always @(posedge clk) begin
        mp_a[0] <= mem_word(int'(fb_addr_a));
        for (int k = 1; k < FBL_A; k++) mp_a[k] <= mp_a[k-1];
        mp_b[0] <= mem_word(int'(fb_addr_b));
        for (int k = 1; k < FBL_B; k++) mp_b[k] <= mp_b[k-1];
    end
    assign fb_data_a = mp_a[FBL_A-1];
    assign fb_data_b = mp_b[FBL_B-1];

    // scoreboard
    int          n_checks = 0;
    int          n_fail = 0;
    logic [26:0] exp_a[$];
    logic [26:0] exp_b[$];
    logic [1:0]  sh_mode = 2'b00;
    logic [7:0]  sh_thr = 8'h80;
    bit          have_prev = 1'b0, prd_a = 1'b0, prd_b = 1'b0, chk_last = 1'b0;
    int          paddr_a = 0, paddr_b = 0, held_a = 0, held_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int win_addr(int x, int y, int wx0, int wy0, int fbw, int fbh, int s);
        if (x < wx0 || x >= wx0 + (fbw << s) || y < wy0 || y >= wy0 + (fbh << s)) return -1;
        return ((y - wy0) >> s) * fbw + ((x - wx0) >> s);
    endfunction

    // reference pixel: what the display should show for one raster sample
    function automatic logic [26:0] pix(int wx0, int wy0, int fbw, int fbh, int s, int ow,
                                        bit act, bit hs, bit vs, int x, int y);
        logic [15:0] d;
        int r, g, b, yl, t, a;
        if (!act) return {1'b0, hs, vs, 24'h0};
        a = win_addr(x, y, wx0, wy0, fbw, fbh, s);
        if (a < 0) begin
            r = 0; g = 0; b = 8'h40;
        end else begin
            d  = mem_word(a);
            r  = (int'(d[15:11]) << 3) | (int'(d[15:11]) >> 2);
            g  = (int'(d[10:5]) << 2) | (int'(d[10:5]) >> 4);
            b  = (int'(d[4:0]) << 3) | (int'(d[4:0]) >> 2);
            yl = r / 4 + g / 2 + b / 8;
            case (sh_mode)
                2'd1: begin r = yl; g = yl; b = yl; end
                2'd2: begin t = (yl > int'(sh_thr)) ? 255 : 0; r = t; g = t; b = t; end
                2'd3: begin t = r; r = b; b = g; g = t; end
                default: ;
            endcase
        end
        return {1'b1, hs, vs, 8'(r >> (8 - ow)), 8'(g >> (8 - ow)), 8'(b >> (8 - ow))};
    endfunction

    // driver: one raster sample per clock; outputs checked before each drive
    task automatic step(bit rst, bit act, int x, int y, bit hs, bit vs,
                        logic [1:0] md, logic [7:0] thr);
        logic [26:0] e;
        int aa, ab;
        @(negedge clk);
        if (exp_a.size() == LA) begin
            e = exp_a.pop_front();
            check("pix_a", {5'b0, de_a, hs_a, vs_a, vga_r_a, vga_g_a, vga_b_a}, {5'b0, e});
        end
        if (exp_b.size() == LB) begin
            e = exp_b.pop_front();
            check("pix_b", {5'b0, de_b, hs_b, vs_b, 3'b0, vga_r_b, 3'b0, vga_g_b, 3'b0, vga_b_b},
                  {5'b0, e});
        end
        if (have_prev) begin
            check("rd_a", 32'(fb_rd_en_a), 32'(prd_a));
            check("addr_a", 32'(fb_addr_a), paddr_a);
            check("rd_b", 32'(fb_rd_en_b), 32'(prd_b));
            check("addr_b", 32'(fb_addr_b), paddr_b);
        end
        if (chk_last) begin
            check("addr_last", 32'(fb_addr_a), 32'd76799);
            chk_last = 1'b0;
        end
        reset = rst; active_in = act; x_in = 10'(x); y_in = 10'(y);
        hsync_in = hs; vsync_in = vs; display_mode = md; threshold = thr;
        have_prev = 1'b1;
        if (rst) begin
            sh_mode = 2'b00; sh_thr = 8'h80;
            for (int i = 0; i < exp_a.size(); i++) exp_a[i] = RST_PIX;
            for (int i = 0; i < exp_b.size(); i++) exp_b[i] = RST_PIX;
            exp_a.push_back(RST_PIX);
            exp_b.push_back(RST_PIX);
            prd_a = 1'b0; prd_b = 1'b0; held_a = 0; held_b = 0; paddr_a = 0; paddr_b = 0;
        end else begin
            if (act && x == 0 && y == 0) begin
                sh_mode = md; sh_thr = thr;
            end
            exp_a.push_back(pix(0, 0, 320, 240, 1, 8, act, hs, vs, x, y));
            exp_b.push_back(pix(100, 40, 160, 100, 0, 5, act, hs, vs, x, y));
            aa = act ? win_addr(x, y, 0, 0, 320, 240, 1) : -1;
            ab = act ? win_addr(x, y, 100, 40, 160, 100, 0) : -1;
            prd_a = (aa >= 0); if (prd_a) held_a = aa; paddr_a = held_a;
            prd_b = (ab >= 0); if (prd_b) held_b = ab; paddr_b = held_b;
            if (act && x == 639 && y == 479) chk_last = 1'b1;
        end
    endtask

    // sparse raster: a fixed set of columns per line plus two random ones
    task automatic frame(logic [1:0] md0, logic [7:0] thr0, int rst_y);
        int  xs [14];
        bit  dead;
        bit  vs;
        int  x;
        dead = 1'b0;
        xs = '{0, 1, 2, 3, 99, 100, 101, 259, 260, 320, 5, 5, 638, 639};
        for (int y = 0; y < 483; y++) begin
            vs = (y != 481);
            if (y < 480 && !dead) begin
                xs[10] = $urandom_range(639, 1);
                xs[11] = $urandom_range(639, 1);
                for (int i = 0; i < 14; i++) begin
                    x = xs[i];
                    if (y == rst_y && x == 320) begin
                        step(1'b1, 1'b1, x, y, 1'b1, vs, 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
                        dead = 1'b1;
                        break;
                    end
                    if (x == 0 && y == 0)
                        step(1'b0, 1'b1, x, y, 1'b1, vs, md0, thr0);
                    else
                        step(1'b0, 1'b1, x, y, 1'b1, vs, 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
                end
            end
            step(1'b0, 1'b0, 640, y, 1'b0, vs, 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
            step(1'b0, 1'b0, 700, y, 1'b1, vs, 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)));
        end
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 700, 0, 1'b1, 1'b1, 2'b00, 8'h80);
        const_en = 1'b1; const_val = 16'hF800;
        frame(2'b00, 8'h80, -1);
        const_en = 1'b0;
        frame(2'b00, 8'($urandom_range(255, 0)), -1);
        frame(2'b11, 8'($urandom_range(255, 0)), -1);
        const_en = 1'b1; const_val = 16'hFFFF;
        frame(2'b01, 8'h00, -1);
        frame(2'b10, 8'hDC, -1);
        frame(2'b10, 8'hDD, 200);
        const_en = 1'b0;
        frame(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)), -1);
        repeat (8) step(1'b0, 1'b0, 700, 490, 1'b1, 1'b1, 2'b00, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scaled_renderer.md
Name: vga_scaled_renderer

Overview:
Parametrised display renderer between the VGA timing generator and the camera frame buffer. It places an upscaled frame-buffer window inside the active raster. Frame-buffer addresses are generated incrementally, without a multiplier. The pipeline tolerates a configurable memory read latency, converts RGB565 to OUT_W-bit RGB in one of four colour modes, and delays hsync/vsync/DE to stay aligned with the pixel data.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
CW, 10, x_in/y_in width
FB_W, 320, frame-buffer columns
FB_H, 240, frame-buffer rows
SCALE_SHIFT, 0..3, default 1, integer upscale factor = 2**SCALE_SHIFT
WIN_X0, 0, window left edge in raster pixels
WIN_Y0, 0, window top edge in raster lines
AW, 17, fb_addr width; must be >= clog2(FB_W*FB_H)
FB_LATENCY, 2, cycles from fb_addr to valid fb_data, 1..4
OUT_W, 8, bits per output colour channel, 4..8
BORDER_RGB, 24'h000040, colour for active pixels outside the window (8:8:8, top OUT_W bits of each used)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
x_in  in  CW  raster column
y_in  in  CW  raster line
active_in  in  1  raster active area
hsync_in  in  1  timing-generator hsync
vsync_in  in  1  timing-generator vsync
display_mode  in  2  00 colour, 01 mono, 10 threshold, 11 false colour
threshold  in  8  luminance threshold for mode 10
fb_addr  out  AW  frame-buffer read address
fb_rd_en  out  1  read strobe
fb_data  in  16  RGB565, valid FB_LATENCY cycles after fb_addr
vga_r/vga_g/vga_b  out  OUT_W each  pixel colour
hsync_out/vsync_out/de_out  out  1 each  delayed sync and data-enable signals

Behaviour:
- Reset values: fb_addr=0, fb_rd_en=0, RGB=0, de_out=0, hsync_out=hsync_in idle level (1), vsync_out=1, mode shadow=00, threshold shadow=8'h80. All delay stages are cleared. Reset mid-frame takes effect on the next clk, and output is black until the pipeline refills.
- Window: raster x in [WIN_X0, WIN_X0+(FB_W<<SCALE_SHIFT)) and y in [WIN_Y0, WIN_Y0+(FB_H<<SCALE_SHIFT)), qualified by active_in.
- Stage A (cycle 0 registered): inside the window, fb_rd_en=1 and fb_addr=row_base+((x_in-WIN_X0)>>SCALE_SHIFT). Otherwise fb_rd_en=0 and fb_addr holds its value.
- row_base register: updated on the x_in==0 cycle of each line.
  - Cleared when y_in==WIN_Y0.
  - Incremented by FB_W when y_in>WIN_Y0, y_in is inside the window, and ((y_in-WIN_Y0) & (2**SCALE_SHIFT-1))==0.
  - Otherwise held. Each FB row is therefore repeated 2**SCALE_SHIFT times.
  - The final window row yields address FB_W*FB_H-1; the address never wraps beyond that.
- Delay line: active, in-window flag, hsync and vsync are delayed by L = FB_LATENCY+2 cycles total. Outputs for raster pixel N appear exactly L cycles after its x_in/y_in.
- Shadow registers: display_mode and threshold load only on the cycle where active_in=1, x_in=0 and y_in=0. Mode changes therefore never tear mid-frame.
- Colour stage (final register):
  - R8={d[15:11],d[15:13]}, G8={d[10:5],d[10:9]}, B8={d[4:0],d[4:2]}.
  - Y=(R8>>2)+(G8>>1)+(B8>>3), 8-bit, max 221, no overflow.
  - Mode 00 outputs R,G,B. Mode 01 outputs Y on all channels. Mode 10 outputs all-ones if Y>threshold shadow, else 0. Mode 11 outputs (B,R,G).
  - Each channel outputs the top OUT_W bits of its 8-bit value.
- Delayed active and out of window: BORDER_RGB. Delayed not active: 0, de_out=0.
- Simultaneous reset and frame start: reset wins, and the shadow takes its reset values.

Optional Feature:
TEST_PATTERN_EN
- Defined:
  - Adds input test_pattern_enable (1 bit), sampled into the shadow at frame start.
  - When set, active pixels show 8 vertical bars, each H_ACTIVE/8 wide. The bar index is counted incrementally per line.
  - Colour = {~idx[2],~idx[1],~idx[0]}, each bit expanded to full scale: bar 0 white, bar 7 black.
  - The pattern bypasses the window, border and mode logic, has the same latency L, and fb_rd_en stays 0.
- Undefined: no port, no logic.

Test Plan:
- Defaults, mode 00, fb_data=16'hF800 at window pixel (0,0) -> vga_r=8'hFF, g=b=0, de_out=1, exactly 4 cycles after x_in=0/y_in=0.
- Defaults, raster lines 0..3 -> fb_addr column 0 sequence 0,0,320,320. At x=639,y=479 -> fb_addr=76799. fb_rd_en never asserts outside the window.
- fb_data=16'hFFFF: mode 01 -> all channels 8'hDD. Mode 10 with threshold 8'hDC -> 8'hFF; with threshold 8'hDD -> 8'h00.
- Change display_mode 00->11 mid-frame at y=100 -> output unchanged until the next frame's (0,0) pixel, then channels are swapped.
- WIN_X0=100, FB_W=160, SCALE_SHIFT=0, pixel x=50 active -> BORDER_RGB output, fb_rd_en=0. Inactive pixel -> RGB=0, de_out=0.
- Assert reset for 1 cycle at x=320 mid-line -> next cycle: all outputs at reset values, pipeline empty. Outputs valid again L cycles after reset deasserts.
